// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: two-requester arbiter driving one FIFO write port.
// Define FIFO_ARB_FIXED_PRIO_EN for fixed priority; default is round-robin with bursts.
module fifo_wr_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  wr_clk_arb,
  input  logic                  wr_rst_arb,
  input  logic                  full_arb,
  input  logic                  req0_valid_arb,
  input  logic                  req1_valid_arb,
  input  logic [DATA_WIDTH-1:0] req0_data_arb,
  input  logic [DATA_WIDTH-1:0] req1_data_arb,
  output logic                  req0_ready_arb,
  output logic                  req1_ready_arb,
  output logic                  wr_inc_arb,
  output logic [DATA_WIDTH-1:0] wr_data_arb,
  output logic                  grant_id_arb,
  output logic                  busy_arb
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PUSH = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    win_q, win_d;
  logic                    gid_q, gid_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    any_req;
  logic                    both_req;
  logic                    pick;
  logic                    rdy0, rdy1, inc;

  assign any_req  = req0_valid_arb | req1_valid_arb;
  assign both_req = req0_valid_arb & req1_valid_arb;

`ifdef FIFO_ARB_FIXED_PRIO_EN
  // Requester 0 always wins when it is valid
  assign pick = ~req0_valid_arb;
`else
  localparam logic [3:0] BL = 4'(BURST_LEN);

  logic       last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic       keep;

  // cnt counts words already written in the current run; zero means no run
  assign keep = (cnt_q != 4'd0) && (cnt_q < BL);
  assign pick = !req0_valid_arb ? 1'b1 :
                !req1_valid_arb ? 1'b0 :
                keep            ? last_q : ~last_q;

  // Burst bookkeeping: clear without contention, count writes per owner
  always_comb begin
    last_d = last_q;
    cnt_d  = cnt_q;
    if (state_q == IDLE && any_req && !full_arb && !both_req)
      cnt_d = 4'd0;
    if (wr_inc_arb) begin
      if (gid_q == last_q) begin
        if (cnt_q != 4'hf)
          cnt_d = cnt_q + 4'd1;
      end else begin
        last_d = gid_q;
        cnt_d  = 4'd1;
      end
    end
  end

  // Last-grant and burst counter registers; reset favours requester 0
  always_ff @(posedge wr_clk_arb) begin
    if (wr_rst_arb) begin
      last_q <= 1'b1;
      cnt_q  <= 4'd0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end
`endif

  // Next-state and handshake outputs; reset suppresses every pulse
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    gid_d   = gid_q;
    data_d  = data_q;
    rdy0    = 1'b0;
    rdy1    = 1'b0;
    inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req && !full_arb) begin
          win_d   = pick;
          state_d = LOAD;
        end
      end
      LOAD: begin
        rdy0    = ~win_q & ~wr_rst_arb;
        rdy1    = win_q & ~wr_rst_arb;
        data_d  = win_q ? req1_data_arb : req0_data_arb;
        gid_d   = win_q;
        state_d = PUSH;
      end
      PUSH: begin
        if (!full_arb) begin
          inc     = ~wr_rst_arb;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, winner, grant and held word registers
  always_ff @(posedge wr_clk_arb) begin
    if (wr_rst_arb) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      gid_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
    end
  end

  assign req0_ready_arb = rdy0;
  assign req1_ready_arb = rdy1;
  assign wr_inc_arb     = inc;
  assign wr_data_arb    = data_q;
  assign grant_id_arb   = gid_q;
  assign busy_arb       = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed and random checks of fifo_wr_arb
// against a transaction-level reference model.
module tb_fifo_wr_arb;
  localparam int DW = 8;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          full = 1'b0;
  logic          v0 = 1'b0, v1 = 1'b0;
  logic [DW-1:0] d0 = '0, d1 = '0;
  logic          r0, r1, inc, gid, busy;
  logic [DW-1:0] wd;

  always #5 clk = ~clk;

  fifo_wr_arb #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .wr_clk_arb     (clk),
    .wr_rst_arb     (rst),
    .full_arb       (full),
    .req0_valid_arb (v0),
    .req1_valid_arb (v1),
    .req0_data_arb  (d0),
    .req1_data_arb  (d1),
    .req0_ready_arb (r0),
    .req1_ready_arb (r1),
    .wr_inc_arb     (inc),
    .wr_data_arb    (wd),
    .grant_id_arb   (gid),
    .busy_arb       (busy)
  );

  int chk = 0;
  int err = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase of the transfer plus arbitration history
  int            ph = 0;
  bit            mw = 0, mg = 0, own = 1;
  int            run = 0;
  logic [DW-1:0] md = '0;

  function automatic bit pick(bit a, bit b);
`ifdef FIFO_ARB_FIXED_PRIO_EN
    return !a;
`else
    if (a && b)
      return (run > 0 && run < BL) ? own : !own;
    return !a;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ph <= 0; own <= 1; run <= 0; md <= '0; mg <= 0;
    end else begin
      case (ph)
        0: if ((v0 || v1) && !full) begin
          mw <= pick(v0, v1);
          if (!(v0 && v1)) run <= 0;
          ph <= 1;
        end
        1: begin
          md <= mw ? d1 : d0;
          mg <= mw;
          ph <= 2;
        end
        default: if (!full) begin
          if (mg == own) run <= (run < 15) ? run + 1 : run;
          else begin own <= mg; run <= 1; end
          ph <= 0;
        end
      endcase
    end
  end

  // Compare process plus accepted-word scoreboard
  int            rd0_cnt = 0, rd1_cnt = 0;
  logic [DW-1:0] sbd[$];
  bit            sbi[$];
  bit            wlog[$];

  always @(negedge clk) begin
    check("rdy0", r0, ph == 1 && mw == 0 && !rst);
    check("rdy1", r1, ph == 1 && mw == 1 && !rst);
    check("inc", inc, ph == 2 && !full && !rst);
    check("busy", busy, ph != 0);
    check("wdata", wd, md);
    check("gid", gid, mg);
    check("excl", (32'(r0) + 32'(r1) + 32'(inc)) <= 1, 1);
    if (r0) begin rd0_cnt++; sbd.push_back(d0); sbi.push_back(0); end
    if (r1) begin rd1_cnt++; sbd.push_back(d1); sbi.push_back(1); end
    if (inc) begin
      wlog.push_back(gid);
      check("sb_nonempty", sbd.size() > 0, 1);
      if (sbd.size() > 0) begin
        check("sb_data", wd, sbd.pop_front());
        check("sb_id", gid, sbi.pop_front());
      end
    end
    if (rst) begin sbd.delete(); sbi.delete(); end
  end

  // Requester agents: hold valid/data until ready, then take next word
  int left0 = 0, left1 = 0;
  int tk0 = 0, tk1 = 0;
  bit gap = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rd0_cnt != tk0) begin
      tk0 = rd0_cnt; if (left0 > 0) left0--; d0 = DW'($urandom); v0 = 0;
    end
    if (rd1_cnt != tk1) begin
      tk1 = rd1_cnt; if (left1 > 0) left1--; d1 = DW'($urandom); v1 = 0;
    end
    if (!v0 && left0 > 0 && (!gap || $urandom_range(3) != 0)) v0 = 1;
    if (!v1 && left1 > 0 && (!gap || $urandom_range(3) != 0)) v1 = 1;
  endtask

  task automatic do_reset();
    rst = 1; full = 0; gap = 0;
    left0 = 0; left1 = 0; v0 = 0; v1 = 0;
    tick();
    tick();
  endtask

  bit exp29[9];
  int base;

  initial begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
    exp29 = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
    exp29 = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
`endif

    // Reset values, then single word A5 from requester 0
    do_reset();
    @(negedge clk);
    check("rst_rdy0", r0, 0);
    check("rst_rdy1", r1, 0);
    check("rst_inc", inc, 0);
    check("rst_data", wd, 0);
    check("rst_gid", gid, 0);
    check("rst_busy", busy, 0);
    tick();
    rst = 0; left0 = 1; d0 = 8'hA5; v0 = 1;
    @(negedge clk);
    check("c1_rdy0", r0, 0);
    tick();
    @(negedge clk);
    check("c2_rdy0", r0, 1);
    tick();
    @(negedge clk);
    check("c3_inc", inc, 1);
    check("c3_data", wd, 8'hA5);
    check("c3_gid", gid, 0);

    // Both requesters continuously valid: burst order
    do_reset();
    tick();
    rst = 0; left0 = 1000; left1 = 1000; v0 = 1; v1 = 1;
    d0 = DW'($urandom); d1 = DW'($urandom);
    base = wlog.size();
    for (int i = 0; i < 60 && wlog.size() < base + 9; i++) tick();
    check("burst_writes", wlog.size() >= base + 9, 1);
    for (int k = 0; k < 9; k++)
      if (base + k < wlog.size())
        check($sformatf("order%0d", k), wlog[base+k], exp29[k]);

    // Full rises during LOAD: five stalled PUSH cycles, one write
    do_reset();
    tick();
    rst = 0; left0 = 1; d0 = 8'h5A; v0 = 1;
    base = wlog.size();
    tick();
    full = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check($sformatf("stall%0d_inc", i), inc, 0);
      check($sformatf("stall%0d_data", i), wd, 8'h5A);
    end
    tick();
    full = 0;
    @(negedge clk);
    check("unstall_inc", inc, 1);
    check("unstall_data", wd, 8'h5A);
    tick();
    tick();
    check("stall_once", wlog.size() - base, 1);

    // Full in IDLE with both valid: nothing starts
    do_reset();
    tick();
    rst = 0; full = 1; left0 = 1; left1 = 1; v0 = 1; v1 = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("fidle%0d_busy", i), busy, 0);
      check($sformatf("fidle%0d_rdy", i), 32'(r0) + 32'(r1), 0);
      tick();
    end
    full = 0;
    tick();
    @(negedge clk);
    check("fidle_rdy0", r0, 1);
    check("fidle_rdy1", r1, 0);

    // Reset while PUSH holds 3C
    do_reset();
    tick();
    rst = 0; left0 = 1; d0 = 8'h3C; v0 = 1;
    tick();
    tick();
    rst = 1;
    base = wlog.size();
    @(negedge clk);
    check("rpush_inc", inc, 0);
    tick();
    rst = 0; left0 = 1; d0 = 8'h11; v0 = 1; left1 = 1; d1 = 8'h22; v1 = 1;
    @(negedge clk);
    check("rpush_data", wd, 0);
    check("rpush_gid", gid, 0);
    check("rpush_busy", busy, 0);
    tick();
    @(negedge clk);
    check("rpush_rdy0", r0, 1);
    check("rpush_nowrite", wlog.size() - base, 0);

    // Only requester 1: ten back-to-back grants
    do_reset();
    tick();
    rst = 0; left1 = 10; d1 = DW'($urandom); v1 = 1;
    base = wlog.size();
    for (int i = 0; i < 45 && wlog.size() < base + 10; i++) tick();
    for (int i = 0; i < 6; i++) tick();
    check("solo1_count", wlog.size() - base, 10);
    for (int k = 0; k < 10; k++)
      if (base + k < wlog.size())
        check($sformatf("solo1_%0d", k), wlog[base+k], 1);

    // Random traffic, full and occasional reset
    do_reset();
    tick();
    rst = 0; gap = 1;
    for (int i = 0; i < 4000; i++) begin
      tick();
      full = ($urandom_range(3) == 0);
      if (left0 == 0 && $urandom_range(7) == 0) left0 = $urandom_range(12, 1);
      if (left1 == 0 && $urandom_range(7) == 0) left1 = $urandom_range(12, 1);
      rst = ($urandom_range(299) == 0);
    end
    tick();
    rst = 0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of requester data and FIFO write data.
REQ-002 Parameter BURST_LEN, default 4: maximum consecutive words granted to one requester while the other is waiting (range 1..15).
REQ-003 wr_clk_arb  input  1  write-domain clock; all logic SHALL be clocked on its rising edge.
REQ-004 wr_rst_arb  input  1  reset; synchronous and active-high.
REQ-005 full_arb  input  1  FIFO full flag from the write-side pointer block.
REQ-006 req0_valid_arb / req1_valid_arb  input  1 each  requester has a word pending.
REQ-007 req0_data_arb / req1_data_arb  input  DATA_WIDTH each  requester word.
REQ-008 req0_ready_arb / req1_ready_arb  output  1 each  one-cycle accept pulse.
REQ-009 wr_inc_arb  output  1  one-cycle FIFO write strobe, driving the write-side increment.
REQ-010 wr_data_arb  output  DATA_WIDTH  registered word presented to FIFO memory.
REQ-011 grant_id_arb  output  1  requester owning the current transfer.
REQ-012 busy_arb  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, LOAD, PUSH.
REQ-014 IDLE: if (req0_valid_arb or req1_valid_arb) and !full_arb, select a winner per REQ-019/020 and go to LOAD; otherwise stay.
REQ-015 LOAD: pulse the winner's ready for this cycle only, latch its data into wr_data_arb, set grant_id_arb, go to PUSH.
REQ-016 PUSH: if !full_arb, assert wr_inc_arb for this cycle and go to IDLE; if full_arb, hold wr_inc_arb low, hold wr_data_arb, stay in PUSH.
REQ-017 Latency: valid sampled in IDLE at cycle N -> ready at N+1 -> wr_inc_arb at N+2 when not full; peak throughput one word per 3 cycles.
REQ-018 Requesters SHALL hold valid and data stable until ready is seen; the block SHALL never pulse ready to a requester that was not valid in the selecting IDLE cycle.
REQ-019 Arbitration: a 1-bit last-grant register and 4-bit burst counter; the last granted requester keeps priority while valid and burst count < BURST_LEN, otherwise priority rotates to the other requester.
REQ-020 The burst counter SHALL increment on each wr_inc_arb to the same requester, clear on a grant change, and clear when the other requester is not valid (no forced rotation without contention).
REQ-021 With only one requester valid, it SHALL win regardless of burst count.
REQ-022 wr_inc_arb, req0_ready_arb, req1_ready_arb SHALL never be high simultaneously with each other in the same cycle.
REQ-023 full_arb rising between IDLE and PUSH SHALL only stall PUSH; the accepted word SHALL be written exactly once when full_arb drops.

Reset
REQ-024 wr_rst_arb high at a clock edge SHALL force state IDLE, last-grant = 1 (so requester 0 wins first), burst counter = 0.
REQ-025 Reset values: all ready outputs 0, wr_inc_arb 0, wr_data_arb 0, grant_id_arb 0, busy_arb 0.
REQ-026 Reset in LOAD or PUSH SHALL discard the held word without asserting wr_inc_arb; a requester already given ready is not re-served.

Configuration
REQ-027 Macro FIFO_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win when both are valid, and the burst counter and last-grant register SHALL be omitted; when undefined, REQ-019/020 round-robin-with-burst SHALL apply.

Verification
REQ-028 Reset then req0_valid=1, data 0xA5, full=0 -> ready0 at cycle 2, wr_inc_arb at cycle 3 with wr_data_arb=0xA5, grant_id_arb=0.
REQ-029 Both requesters continuously valid, BURST_LEN=4, macro undefined -> write order 0,0,0,0,1,1,1,1,0...; with macro defined -> all writes from requester 0.
REQ-030 Word accepted, full_arb=1 for 5 cycles in PUSH -> wr_inc_arb low for those 5 cycles, wr_data_arb stable, one wr_inc_arb on the first cycle full_arb=0.
REQ-031 full_arb=1 in IDLE with both valid -> no ready pulses, busy_arb=0 until full drops.
REQ-032 Reset asserted in PUSH with data 0x3C held -> no wr_inc_arb, all outputs zero next cycle, next grant goes to requester 0.
REQ-033 Only req1 valid for 10 words -> 10 consecutive grants to requester 1, no stall from the burst limit.
